// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache miss path: critical-word-first line reads and
// single-word stores. Defining MEM_STATS_EN adds the readCount/writeCount outputs.
module main_memory_responder #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int OFFSET_W      = 4,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic                reqWrite,
  input  logic [ADDR_W-1:0]   reqAddress,
  input  logic [DATA_W-1:0]   reqWriteData,
  output logic                rspValid,
  output logic [OFFSET_W-1:0] rspWordIndex,
  output logic [DATA_W-1:0]   rspReadData,
  output logic                rspLast,
  output logic                writeDone,
`ifdef MEM_STATS_EN
  output logic [15:0]         readCount,
  output logic [15:0]         writeCount,
`endif
  output logic                busy
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int LAST_BEAT = (1 << OFFSET_W) - 1;
  localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int LAT_W     = $clog2(MAX_LAT + 1);
  localparam int BEAT_W    = OFFSET_W + 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [OFFSET_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                write_done_q, write_done_d;

  logic                accept;
  logic                mem_we;
  logic [OFFSET_W-1:0] burst_idx;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_word;

  // Words are stored XORed with their own address, so a zero-initialised array
  // reads back as word[i] = i without any load step.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign accept    = (state_q == IDLE) && req_ready_q && reqValid;
  assign burst_idx = addr_q[OFFSET_W-1:0] + beat_q[OFFSET_W-1:0];
  assign rd_addr   = {addr_q[ADDR_W-1:OFFSET_W], burst_idx};
  assign rd_word   = mem_q[rd_addr] ^ DATA_W'(rd_addr);

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_idx_d    = rsp_idx_q;
    rsp_data_d   = rsp_data_q;
    rsp_last_d   = rsp_last_q;
    write_done_d = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_idx_d   = '0;
        rsp_data_d  = '0;
        if (accept) begin
          req_ready_d = 1'b0;
          addr_d      = reqAddress;
          wdata_d     = reqWriteData;
          lat_d       = '0;
          state_d     = reqWrite ? WR_WAIT : RD_WAIT;
        end else begin
          // First IDLE cycle after a transaction only re-opens the request port.
          req_ready_d = 1'b1;
        end
      end
      RD_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          beat_d  = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        rsp_valid_d = 1'b1;
        rsp_idx_d   = burst_idx;
        rsp_data_d  = rd_word;
        rsp_last_d  = (beat_q == BEAT_W'(LAST_BEAT));
        beat_d      = beat_q + 1'b1;
        if (beat_q == BEAT_W'(LAST_BEAT)) state_d = IDLE;
      end
      WR_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_W'(WRITE_LATENCY - 1)) begin
          mem_we       = 1'b1;
          write_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      beat_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_idx_q    <= '0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_data_q   <= rsp_data_d;
      rsp_last_q   <= rsp_last_d;
      write_done_q <= write_done_d;
    end
  end

  // The array has no reset; a reset during WR_WAIT forces IDLE, so mem_we never fires.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= wdata_q ^ DATA_W'(addr_q);
  end

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept && !reqWrite && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (accept &&  reqWrite && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign readCount  = rd_cnt_q;
  assign writeCount = wr_cnt_q;
`endif

  assign reqReady     = req_ready_q;
  assign busy         = ~req_ready_q;
  assign rspValid     = rsp_valid_q;
  assign rspWordIndex = rsp_idx_q;
  assign rspReadData  = rsp_data_q;
  assign rspLast      = rsp_last_q;
  assign writeDone    = write_done_q;

endmodule
